// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC frame sequencer.
// Holds the sequencer state enum, register map and default read value.
package lpc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StLdrClr,
        StLdrRun,
        StFeRun,
        StPublish
    } seq_state_e;

    localparam logic [15:0] AddrRate     = 16'h0000;
    localparam logic [15:0] AddrStatus   = 16'h0001;
    localparam logic [15:0] AddrFrameCnt = 16'h0002;
    localparam logic [15:0] RdDefault    = 16'h0bad;

endpackage

// File: rtl/lpc_seq_regs.sv
// Avalon-MM register file for the LPC frame sequencer: rate, sticky status
// flags with write-one-to-clear, and the read-only frame counter.
module lpc_seq_regs
    import lpc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [15:0] writedata_i,
    input  logic        ovr_set_i,
    input  logic        tmo_set_i,
    input  logic [15:0] frame_cnt_i,
    output logic [15:0] readdata_o,
    output logic [15:0] rate_o,
    output logic        overrun_o,
    output logic        timeout_o
);

    logic [15:0] rate_q, rate_d;
    logic        ovr_q, ovr_d;
    logic        tmo_q, tmo_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] rd_mux;

    always_comb begin
        rate_d = rate_q;
        ovr_d  = ovr_q;
        tmo_d  = tmo_q;
        if (write_i && address_i == AddrRate) begin
            rate_d = writedata_i;
        end
        if (write_i && address_i == AddrStatus) begin
            if (writedata_i[0]) ovr_d = 1'b0;
            if (writedata_i[1]) tmo_d = 1'b0;
        end
        // A new error event in the same cycle beats the clear.
        if (ovr_set_i) ovr_d = 1'b1;
        if (tmo_set_i) tmo_d = 1'b1;
    end

    always_comb begin
        rd_mux = RdDefault;
        case (address_i)
            AddrRate:     rd_mux = rate_q;
            AddrStatus:   rd_mux = {14'b0, tmo_q, ovr_q};
            AddrFrameCnt: rd_mux = frame_cnt_i;
            default:      rd_mux = RdDefault;
        endcase
        rdata_d = read_i ? rd_mux : 16'h0000;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rate_q  <= 16'h0000;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            rate_q  <= rate_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata_o = rdata_q;
    assign rate_o     = rate_q;
    assign overrun_o  = ovr_q;
    assign timeout_o  = tmo_q;

endmodule

// File: rtl/lpc_frame_seq.sv
// LPC frame sequencer: collects a frame of samples, then drives LDR solve,
// pitch estimation and publish. Define LPC_SEQ_WDOG_EN for the LDR watchdog.
module lpc_frame_seq
    import lpc_pkg::*;
#(
    parameter int unsigned AW  = 8,
    parameter int unsigned TMO = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_v,
    output logic          ldr_start,
    output logic          ldr_rst,
    input  logic          ldr_done,
    output logic          fe_v,
    output logic          fe_rst,
    output logic [AW-1:0] fe_addr,
    output logic          peak_v,
    output logic          peak_rst,
    output logic          frame_valid,
    output logic          overrun,
    output logic          timeout,
    input  logic [15:0]   address,
    input  logic          read,
    input  logic          write,
    input  logic [15:0]   writedata,
    output logic [15:0]   readdata
);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] rate_act_q, rate_act_d;
    logic [AW-1:0] proc_rate_q, proc_rate_d;
    logic [AW-1:0] fe_addr_q, fe_addr_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          ldr_first_q, ldr_first_d;
    logic [15:0]   rate_reg;
    logic          boundary;
    logic          ovr_set;
    logic          tmo_set;

`ifdef LPC_SEQ_WDOG_EN
    localparam int unsigned WW = (TMO < 2) ? 1 : $clog2(TMO + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    assign wdog_d = (state_q == StLdrRun) ? wdog_q + 1'b1 : '0;
`endif

    // Index runs whenever the sequencer is active, so the next frame is
    // gathered while the current one is still being processed.
    assign boundary = sample_v && (idx_q == rate_act_q) && (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rate_act_d  = rate_act_q;
        proc_rate_d = proc_rate_q;
        fe_addr_d   = fe_addr_q;
        frame_cnt_d = frame_cnt_q;
        ldr_start   = 1'b0;
        ldr_rst     = 1'b0;
        fe_v        = 1'b0;
        fe_rst      = 1'b0;
        peak_v      = 1'b0;
        peak_rst    = 1'b0;
        frame_valid = 1'b0;
        ovr_set     = 1'b0;
        tmo_set     = 1'b0;

        if (state_q != StIdle && sample_v) begin
            if (boundary) begin
                idx_d      = '0;
                rate_act_d = rate_reg[AW-1:0];
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (boundary && state_q != StCollect) ovr_set = 1'b1;

        case (state_q)
            StIdle: begin
                if (|rate_reg) begin
                    state_d    = StCollect;
                    rate_act_d = rate_reg[AW-1:0];
                    idx_d      = '0;
                end
            end
            StCollect: begin
                peak_v = 1'b1;
                if (boundary) begin
                    state_d     = StLdrClr;
                    proc_rate_d = rate_act_q;
                end
            end
            StLdrClr: begin
                ldr_rst = 1'b1;
                fe_rst  = 1'b1;
                state_d = StLdrRun;
            end
            StLdrRun: begin
                ldr_start = ldr_first_q;
                if (ldr_done) begin
                    state_d   = StFeRun;
                    fe_addr_d = '0;
                end
`ifdef LPC_SEQ_WDOG_EN
                else if (wdog_q == WW'(TMO)) begin
                    tmo_set = 1'b1;
                    ldr_rst = 1'b1;
                    state_d = StCollect;
                end
`endif
            end
            StFeRun: begin
                fe_v = 1'b1;
                if (fe_addr_q == proc_rate_q) begin
                    fe_addr_d = '0;
                    state_d   = StPublish;
                end else begin
                    fe_addr_d = fe_addr_q + 1'b1;
                end
            end
            StPublish: begin
                frame_valid = 1'b1;
                peak_rst    = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = StCollect;
            end
            default: state_d = StIdle;
        endcase
    end

    assign ldr_first_d = (state_q == StLdrClr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            rate_act_q  <= '0;
            proc_rate_q <= '0;
            fe_addr_q   <= '0;
            frame_cnt_q <= 16'h0000;
            ldr_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rate_act_q  <= rate_act_d;
            proc_rate_q <= proc_rate_d;
            fe_addr_q   <= fe_addr_d;
            frame_cnt_q <= frame_cnt_d;
            ldr_first_q <= ldr_first_d;
        end
    end

`ifdef LPC_SEQ_WDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wdog_q <= '0;
        else      wdog_q <= wdog_d;
    end
`endif

    assign fe_addr = fe_addr_q;

    lpc_seq_regs u_regs (
        .clk_i       (clk),
        .rst_ni      (rst),
        .address_i   (address),
        .read_i      (read),
        .write_i     (write),
        .writedata_i (writedata),
        .ovr_set_i   (ovr_set),
        .tmo_set_i   (tmo_set),
        .frame_cnt_i (frame_cnt_q),
        .readdata_o  (readdata),
        .rate_o      (rate_reg),
        .overrun_o   (overrun),
        .timeout_o   (timeout)
    );

endmodule

// File: tb/tb_lpc_frame_seq.sv
// Directed bench for lpc_frame_seq; with LPC_SEQ_WDOG_EN it also covers the
// LDR watchdog using TMO=15.
module tb_lpc_frame_seq;

`ifdef LPC_SEQ_WDOG_EN
    localparam int unsigned TbTmo = 15;
`else
    localparam int unsigned TbTmo = 1023;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_v = 1'b0;
    logic        ldr_start, ldr_rst;
    logic        ldr_done = 1'b0;
    logic        fe_v, fe_rst;
    logic [7:0]  fe_addr;
    logic        peak_v, peak_rst, frame_valid, overrun, timeout;
    logic [15:0] address = 16'h0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] writedata = 16'h0;
    logic [15:0] readdata;

    int n_total = 0;
    int n_bad   = 0;

    lpc_frame_seq #(.AW(8), .TMO(TbTmo)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_v    (sample_v),
        .ldr_start   (ldr_start),
        .ldr_rst     (ldr_rst),
        .ldr_done    (ldr_done),
        .fe_v        (fe_v),
        .fe_rst      (fe_rst),
        .fe_addr     (fe_addr),
        .peak_v      (peak_v),
        .peak_rst    (peak_rst),
        .frame_valid (frame_valid),
        .overrun     (overrun),
        .timeout     (timeout),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [15:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
        check_val(tag, {16'h0, readdata}, {16'h0, exp});
    endtask

    task automatic check_quiet(input string tag);
        check_val(tag, {ldr_start, ldr_rst, fe_v, fe_rst, peak_v, peak_rst, frame_valid,
                        overrun, timeout}, 32'h0);
        check_val({tag, "_addr"}, {24'h0, fe_addr}, 32'h0);
        check_val({tag, "_rdata"}, {16'h0, readdata}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=stuck exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check_quiet("reset");
        rst = 1'b1;
        repeat (3) tick();
        check_val("idle_rate0_peak", {31'h0, peak_v}, 32'h0);
        reg_read("rate_rst", 16'h0, 16'h0);

        // Normal frame with rate=7
        reg_write(16'h0, 16'd7);
        reg_read("rate_rd", 16'h0, 16'd7);
        check_val("collect_peak", {31'h0, peak_v}, 32'h1);
        sample_v = 1'b1;
        repeat (8) tick();
        sample_v = 1'b0;
        check_val("ldrclr", {28'h0, ldr_rst, fe_rst, peak_v, ldr_start}, 32'b1100);
        tick();
        check_val("ldrstart", {30'h0, ldr_start, ldr_rst}, 32'b10);
        tick();
        check_val("ldrstart_once", {31'h0, ldr_start}, 32'h0);
        repeat (3) tick();
        ldr_done = 1'b1;
        tick();
        ldr_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("fe_step%0d", i), {23'h0, fe_v, fe_addr}, {23'h0, 1'b1, 8'(i)});
            tick();
        end
        check_val("publish", {29'h0, frame_valid, peak_rst, fe_v}, 32'b110);
        tick();
        check_val("publish_once", {30'h0, frame_valid, peak_v}, 32'b01);
        reg_read("frame_cnt1", 16'h2, 16'd1);
        tick();
        check_val("rdata_idle", {16'h0, readdata}, 32'h0);

        // Unmapped address
        reg_read("bad_addr", 16'h5, 16'h0bad);
        tick();
        check_val("bad_addr_clr", {16'h0, readdata}, 32'h0);

        // Overrun: second boundary while waiting in LDR_RUN
        sample_v = 1'b1;
        repeat (16) tick();
        sample_v = 1'b0;
        check_val("ovr_pin", {31'h0, overrun}, 32'h1);
        reg_read("status_ovr", 16'h1, 16'h0001);
        reg_write(16'h1, 16'h0001);
        reg_read("status_clr", 16'h1, 16'h0000);
        ldr_done = 1'b1;
        tick();
        ldr_done = 1'b0;
        check_val("fe0_after_ovr", {23'h0, fe_v, fe_addr}, {23'h0, 9'h100});
        tick();
        tick();
        check_val("fe2_after_ovr", {23'h0, fe_v, fe_addr}, {23'h0, 9'h102});

        // Asynchronous reset during FE_RUN
        rst = 1'b0;
        #1;
        check_quiet("async_rst");
        tick();
        rst = 1'b1;
        repeat (4) tick();
        check_val("post_rst_idle", {31'h0, peak_v}, 32'h0);
        reg_read("post_rst_rate", 16'h0, 16'h0);
        reg_read("post_rst_cnt", 16'h2, 16'h0);

`ifdef LPC_SEQ_WDOG_EN
        begin
            int n;
            logic fv_seen;
            n = 0;
            fv_seen = 1'b0;
            reg_write(16'h0, 16'd7);
            tick();
            sample_v = 1'b1;
            repeat (8) tick();
            sample_v = 1'b0;
            check_val("wd_ldrclr", {31'h0, ldr_rst}, 32'h1);
            tick();
            check_val("wd_ldrstart", {31'h0, ldr_start}, 32'h1);
            while (!ldr_rst && n < 40) begin
                tick();
                n++;
                if (frame_valid) fv_seen = 1'b1;
            end
            check_val("wd_cycles", n, 32'd15);
            tick();
            check_val("wd_flag", {30'h0, timeout, peak_v}, 32'b11);
            repeat (12) begin
                if (frame_valid) fv_seen = 1'b1;
                tick();
            end
            check_val("wd_no_fv", {31'h0, fv_seen}, 32'h0);
            reg_read("wd_status", 16'h1, 16'h0002);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lpc_frame_seq.md
LPC_FRAME_SEQ -- requirements
Module: lpc_frame_seq

Interface
REQ-001 Parameter AW, default 8: width of the frame sample index and buffer address.
REQ-002 Parameter TMO, default 1023: LDR watchdog limit in clk cycles.
REQ-003 clk  in  1  single system clock; all logic rises on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 sample_v  in  1  one-cycle strobe per accepted input sample.
REQ-006 ldr_start / ldr_rst  out  1/1  LDR solver start pulse / LDR solver clear pulse.
REQ-007 ldr_done  in  1  LDR solver completion level.
REQ-008 fe_v / fe_rst / fe_addr  out  1/1/AW  pitch estimator enable / clear / sample-buffer read address.
REQ-009 peak_v / peak_rst  out  1/1  peak detector enable / clear.
REQ-010 frame_valid  out  1  one-cycle pulse when coefficients and pitch for a frame are ready to latch.
REQ-011 overrun / timeout  out  1/1  sticky error flags.
REQ-012 address[15:0], read, write, writedata[15:0] in; readdata[15:0] out: Avalon-MM slave interface.

Function
REQ-013 Registers: 0x0 rate (R/W, frame length minus one); 0x1 status (R, {14'b0, timeout, overrun}, write 1 clears each bit); 0x2 frame_cnt (R); any other address reads 16'hbad, and writes to it are ignored.
REQ-014 readdata is registered: it carries the addressed value one cycle after read=1, and 0 when read=0.
REQ-015 States: IDLE, COLLECT, LDR_CLR, LDR_RUN, FE_RUN, PUBLISH.
REQ-016 IDLE -> COLLECT when rate != 0; IDLE holds and all strobes stay 0 while rate == 0.
REQ-017 COLLECT: peak_v=1; sample index increments on sample_v; at index == rate with sample_v, the index wraps to 0 and the state goes to LDR_CLR.
REQ-018 LDR_CLR (1 cycle): ldr_rst=1, fe_rst=1, peak_v=0; next state LDR_RUN.
REQ-019 LDR_RUN: ldr_start=1 in the first cycle only; the state waits for ldr_done=1, then goes to FE_RUN.
REQ-020 FE_RUN: fe_v=1; fe_addr steps 0..rate, one per cycle; after the address equal to rate, the state goes to PUBLISH.
REQ-021 PUBLISH (1 cycle): frame_valid=1, peak_rst=1, frame_cnt increments (wrapping at 16 bits); next state COLLECT.
REQ-022 In COLLECT the sample index keeps counting in all states, so collection of the next frame overlaps processing of the current one.
REQ-023 A frame boundary while the state is not COLLECT sets overrun; that frame is dropped and the sequence in progress completes.
REQ-024 A rate write takes effect at the next frame boundary only; rate is never altered mid-frame.
REQ-025 Simultaneous W1C write and a new error event: the set wins.

Reset
REQ-026 While rst is low: state=IDLE, rate=0, frame_cnt=0, index=0, fe_addr=0, all strobes=0, flags=0, readdata=0.
REQ-027 Reset asserted mid-sequence aborts immediately; the first frame after release is a complete new frame.

Configuration
REQ-028 Macro LPC_SEQ_WDOG_EN.
- Defined: LDR_RUN counts cycles; at count == TMO the block sets timeout, pulses ldr_rst, and returns to COLLECT without frame_valid.
- Undefined: LDR_RUN waits on ldr_done indefinitely, and the timeout flag is tied to 0.

Structure
REQ-029 Shared package lpc_pkg holds the state enum, register address constants, and the 16'hbad default read value.
REQ-030 One sub-module, lpc_seq_regs, implements the Avalon-MM register file; the FSM and counters stay in the top module.

Verification
REQ-031 Write rate=7, then 8 sample_v pulses -> one-cycle ldr_rst, then a one-cycle ldr_start; ldr_done after 5 cycles -> fe_addr 0..7 on consecutive cycles, then frame_valid, and frame_cnt reads 1.
REQ-032 Read of address 0x5 -> readdata=16'hbad on the next cycle; read=0 -> readdata=0.
REQ-033 ldr_done held low with a 2nd frame boundary arriving during LDR_RUN -> status reads 0x0001; write 0x0001 to 0x1 -> status reads 0.
REQ-034 LPC_SEQ_WDOG_EN defined, TMO=15, ldr_done never asserts -> timeout set at cycle 15, ldr_rst pulse, no frame_valid.
REQ-035 rst driven low during FE_RUN -> outputs at reset values immediately; after release, rate=0 keeps the FSM in IDLE.
